// File: rtl/color_sensor_emulator_pkg.sv
// Shared colour-link constants: filter/scale codes, scale multipliers and FSM state encoding.
// Both this emulator and the colour reader import these so the two ends agree.
package colour_pkg;

  localparam int SETTLE_CYCLES_DEF = 8;
  localparam int LVL_W_DEF         = 8;
  localparam int CNT_W_DEF         = 14;

  localparam logic [1:0] FLT_RED   = 2'b00;
  localparam logic [1:0] FLT_BLUE  = 2'b01;
  localparam logic [1:0] FLT_CLEAR = 2'b10;
  localparam logic [1:0] FLT_GREEN = 2'b11;

  localparam logic [1:0] SCL_PWRDN  = 2'b00;
  localparam logic [1:0] SCL_2PCT   = 2'b01;
  localparam logic [1:0] SCL_20PCT  = 2'b10;
  localparam logic [1:0] SCL_100PCT = 2'b11;

  localparam logic [5:0] MULT_2PCT   = 6'd50;
  localparam logic [5:0] MULT_20PCT  = 6'd5;
  localparam logic [5:0] MULT_100PCT = 6'd1;

  typedef enum logic [1:0] {
    ST_PWRDN  = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2,
    ST_DARK   = 2'd3
  } state_e;

  function automatic logic [5:0] scale_mult(input logic [1:0] scl);
    case (scl)
      SCL_2PCT:   return MULT_2PCT;
      SCL_20PCT:  return MULT_20PCT;
      SCL_100PCT: return MULT_100PCT;
      default:    return 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/color_sensor_emulator_if.sv
// Sensor-side bundle of the colour link: select/enable lines from the reader,
// light-level programming inputs, and the emulated frequency output.
interface color_sensor_emulator_if #(
  parameter int LVL_W = 8
);
  logic             s0;
  logic             s1;
  logic             s2;
  logic             s3;
  logic             oe_n;
  logic [LVL_W-1:0] r_level;
  logic [LVL_W-1:0] g_level;
  logic [LVL_W-1:0] b_level;
  logic [LVL_W-1:0] c_level;
  logic             freq_out;
  logic [1:0]       filter_sel;

  modport master (
    output s0, s1, s2, s3, oe_n, r_level, g_level, b_level, c_level,
    input  freq_out, filter_sel
  );

  modport slave (
    input  s0, s1, s2, s3, oe_n, r_level, g_level, b_level, c_level,
    output freq_out, filter_sel
  );
endinterface

// File: rtl/color_sensor_emulator_sync2.sv
// Two-flop synchroniser for a single asynchronous control line.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/color_sensor_emulator.sv
// TCS3200-style sensor model: decodes filter/scale selects and drives a 50%-duty
// square wave whose half-period is level*scale clk cycles.
module color_sensor_emulator
  import colour_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int LVL_W         = LVL_W_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input logic                     clk,
  input logic                     rst,
  color_sensor_emulator_if.slave  bus
);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  logic [4:0]       w_async;
  logic [4:0]       w_sync;
  logic [1:0]       w_scale;
  logic [1:0]       w_filt;
  logic             w_oe_n;
  logic [LVL_W-1:0] w_level;
  logic [CNT_W-1:0] w_hp;
  logic             w_changed;
  logic             w_settle_req;

  state_e           r_state, w_state_next;
  logic [1:0]       r_filt, w_filt_next;
  logic [1:0]       r_scale, w_scale_next;
  logic [SET_W-1:0] r_settle_cnt, w_settle_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [CNT_W-1:0] r_hp, w_hp_next;
  logic             r_freq, w_freq_next;

  assign w_async = {bus.oe_n, bus.s3, bus.s2, bus.s1, bus.s0};

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_sync
      sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (w_async[gi]),
        .o_q (w_sync[gi])
      );
    end
  endgenerate

  assign w_scale = {w_sync[0], w_sync[1]};
  assign w_filt  = {w_sync[2], w_sync[3]};
  assign w_oe_n  = w_sync[4];

  // Level follows the latched filter, so a filter change never leaks into the
  // running waveform before the settle interval has started.
  always_comb begin
    case (r_filt)
      FLT_RED:   w_level = bus.r_level;
      FLT_BLUE:  w_level = bus.b_level;
      FLT_CLEAR: w_level = bus.c_level;
      default:   w_level = bus.g_level;
    endcase
  end

  assign w_hp         = CNT_W'(w_level) * CNT_W'(scale_mult(r_scale));
  assign w_changed    = (w_filt != r_filt) || (w_scale != r_scale);
  assign w_settle_req = (w_scale != SCL_PWRDN) && ((r_state == ST_PWRDN) || w_changed);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_PWRDN;
      r_filt       <= 2'b00;
      r_scale      <= 2'b00;
      r_settle_cnt <= '0;
      r_cnt        <= '0;
      r_hp         <= '0;
      r_freq       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_filt       <= w_filt_next;
      r_scale      <= w_scale_next;
      r_settle_cnt <= w_settle_next;
      r_cnt        <= w_cnt_next;
      r_hp         <= w_hp_next;
      r_freq       <= w_freq_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_filt_next   = r_filt;
    w_scale_next  = r_scale;
    w_settle_next = r_settle_cnt;
    w_cnt_next    = r_cnt;
    w_hp_next     = r_hp;
    w_freq_next   = r_freq;

    if (w_settle_req) begin
      w_state_next  = ST_SETTLE;
      w_filt_next   = w_filt;
      w_scale_next  = w_scale;
      w_settle_next = '0;
      w_freq_next   = 1'b0;
    end else if (w_scale == SCL_PWRDN) begin
      w_state_next = ST_PWRDN;
      w_freq_next  = 1'b0;
    end else begin
      case (r_state)
        ST_SETTLE: begin
          w_freq_next = 1'b0;
          if (r_settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
            if (w_level == '0) begin
              w_state_next = ST_DARK;
            end else begin
              w_state_next = ST_RUN;
              w_freq_next  = 1'b1;
              w_cnt_next   = CNT_W'(1);
              w_hp_next    = w_hp;
            end
          end else begin
            w_settle_next = r_settle_cnt + SET_W'(1);
          end
        end
        ST_RUN: begin
          // Half-period is re-sampled only at edges so level updates never glitch.
          if (r_cnt == r_hp) begin
            if (w_level == '0) begin
              w_state_next = ST_DARK;
              w_freq_next  = 1'b0;
            end else begin
              w_freq_next = ~r_freq;
              w_cnt_next  = CNT_W'(1);
              w_hp_next   = w_hp;
            end
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
        ST_DARK: begin
          w_freq_next = 1'b0;
          if (w_level != '0) begin
            w_state_next = ST_RUN;
            w_freq_next  = 1'b1;
            w_cnt_next   = CNT_W'(1);
            w_hp_next    = w_hp;
          end
        end
        default: begin
          w_freq_next = 1'b0;
        end
      endcase
    end
  end

  // Output enable only masks the pin; the waveform keeps its phase underneath.
  assign bus.freq_out   = r_freq & ~w_oe_n;
  assign bus.filter_sel = r_filt;
endmodule

// File: tb/tb_color_sensor_emulator.sv
// Self-checking bench for color_sensor_emulator: vector table of half-periods,
// hand sequences for dark/oe/reset corners, and randomized segments vs. a waveform model.
module tb_color_sensor_emulator;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  color_sensor_emulator_if #(.LVL_W(8)) bus ();

  color_sensor_emulator #(
    .SETTLE_CYCLES (8),
    .LVL_W         (8),
    .CNT_W         (14)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] s01;
    logic [1:0] s23;
    logic [7:0] lvl;
    int         exp_hp;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Selected filter gets lvl; the others get distinct nonzero decoys.
  task automatic apply(input logic [1:0] s01, input logic [1:0] s23,
                       input logic [7:0] lvl, input logic oe);
    bus.s0 = s01[1];
    bus.s1 = s01[0];
    bus.s2 = s23[1];
    bus.s3 = s23[0];
    bus.oe_n = oe;
    bus.r_level = lvl + 8'd11;
    bus.b_level = lvl + 8'd23;
    bus.c_level = lvl + 8'd37;
    bus.g_level = lvl + 8'd53;
    case (s23)
      2'b00:   bus.r_level = lvl;
      2'b01:   bus.b_level = lvl;
      2'b10:   bus.c_level = lvl;
      default: bus.g_level = lvl;
    endcase
  endtask

  function automatic int mult(input logic [1:0] s01);
    case (s01)
      2'b01:   return 50;
      2'b10:   return 5;
      2'b11:   return 1;
      default: return 0;
    endcase
  endfunction

  // Sample n cycles after an input change: 2 sync + 1 decision, 8 settle, then
  // a square wave starting high with half-period level*multiplier.
  function automatic int exp_freq(input int n, input int lvl, input logic [1:0] s01, input logic oe);
    int hp;
    if (s01 == 2'b00 || oe || n < 11 || lvl == 0) return 0;
    hp = lvl * mult(s01);
    return (((n - 11) / hp) % 2 == 0) ? 1 : 0;
  endfunction

  task automatic wait_rise(output int lowc, output bit rose);
    lowc = 0;
    rose = 1'b0;
    for (int k = 0; k < 60 && !rose; k++) begin
      step();
      if (bus.freq_out) rose = 1'b1;
      else lowc++;
    end
  endtask

  initial begin
    int lowc, highc, lowr;
    bit rose;
    logic [1:0] prev_s01, prev_s23, s01, s23;
    int lvl, len;
    logic oe;

    tbl[0] = '{2'b11, 2'b00, 8'd10, 10};
    tbl[1] = '{2'b11, 2'b11, 8'd4,  4};
    tbl[2] = '{2'b01, 2'b01, 8'd3,  150};
    tbl[3] = '{2'b10, 2'b01, 8'd3,  15};
    tbl[4] = '{2'b11, 2'b10, 8'd0,  0};
    tbl[5] = '{2'b10, 2'b11, 8'd9,  45};

    rst = 1'b1;
    apply(2'b00, 2'b00, 8'd0, 1'b0);
    step();
    step();
    check("reset_freq", int'(bus.freq_out), 0);
    check("reset_sel", int'(bus.filter_sel), 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 6; i++) begin
      apply(tbl[i].s01, tbl[i].s23, tbl[i].lvl, 1'b0);
      step();
      step();
      wait_rise(lowc, rose);
      if (tbl[i].exp_hp == 0) begin
        check("dark_no_rise", int'(rose), 0);
      end else begin
        check("settle_low", lowc, 8);
        if (rose) begin
          highc = 1;
          for (int k = 0; k < 400; k++) begin
            step();
            if (!bus.freq_out) break;
            highc++;
          end
          lowr = 1;
          for (int k = 0; k < 400; k++) begin
            step();
            if (bus.freq_out) break;
            lowr++;
          end
          check("half_high", highc, tbl[i].exp_hp);
          check("half_low", lowr, tbl[i].exp_hp);
        end
      end
      check("vec_sel", int'(bus.filter_sel), int'(tbl[i].s23));
      $display("vec %0d scale=%b filt=%b lvl=%0d hp=%0d", i, tbl[i].s01, tbl[i].s23, tbl[i].lvl, tbl[i].exp_hp);
      if (i == 4) begin
        bus.c_level = 8'd1;
        for (int n = 1; n <= 6; n++) begin
          step();
          check("dark_to_clk2", int'(bus.freq_out), n % 2);
        end
        $display("seq dark->c_level=1 clk/2 toggle");
      end
    end

    apply(2'b11, 2'b00, 8'd10, 1'b0);
    step();
    step();
    wait_rise(lowc, rose);
    check("oe_pre_rise", int'(rose), 1);
    bus.oe_n = 1'b1;
    for (int j = 1; j <= 70; j++) begin
      step();
      if (j >= 3 && j <= 30) check("oe_masked", int'(bus.freq_out), 0);
      if (j >= 33) check("oe_resume", int'(bus.freq_out), ((j / 10) % 2 == 0) ? 1 : 0);
      if (j == 30) bus.oe_n = 1'b0;
    end
    $display("seq oe_n pulse 30 cycles");

    prev_s01 = 2'b11;
    prev_s23 = 2'b00;
    for (int seg = 0; seg < 40; seg++) begin
      s01 = 2'($urandom_range(0, 3));
      if (s01 == 2'b00 && ($urandom % 2 == 0)) s01 = 2'b11;
      s23 = 2'($urandom_range(0, 3));
      if (s01 == prev_s01 && s23 == prev_s23) s23 = s23 ^ 2'b01;
      if ($urandom % 8 == 0) lvl = 0;
      else if (s01 == 2'b01) lvl = int'($urandom_range(1, 4));
      else lvl = int'($urandom_range(1, 30));
      oe = ($urandom % 5 == 0);
      len = int'($urandom_range(30, 80));
      apply(s01, s23, 8'(lvl), oe);
      for (int n = 1; n <= len; n++) begin
        step();
        if (n >= 3) begin
          check("rand_freq", int'(bus.freq_out), exp_freq(n, lvl, s01, oe));
          if (s01 != 2'b00) check("rand_sel", int'(bus.filter_sel), int'(s23));
        end
      end
      $display("rand %0d scale=%b filt=%b lvl=%0d oe_n=%0d len=%0d", seg, s01, s23, lvl, oe, len);
      prev_s01 = s01;
      prev_s23 = s23;
    end

    apply(2'b11, 2'b11, 8'd6, 1'b0);
    step();
    step();
    wait_rise(lowc, rose);
    check("rst_pre_rise", int'(rose), 1);
    step();
    #2;
    rst = 1'b1;
    bus.s0 = 1'b0;
    bus.s1 = 1'b0;
    #1;
    check("rst_async_freq", int'(bus.freq_out), 0);
    check("rst_async_sel", int'(bus.filter_sel), 0);
    step();
    step();
    rst = 1'b0;
    for (int n = 0; n < 30; n++) begin
      step();
      check("pwrdn_low", int'(bus.freq_out), 0);
    end
    $display("seq async reset mid-run, then power-down");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
